// File: rtl/kernel_attention_mul_arbiter.sv
// Round-robin front end for one shared pipelined 10x6 multiplier: picks one requester per
// enabled cycle and carries its id alongside the product through a LAT-deep tag pipeline.
module kernel_attention_mul_arbiter #(
    parameter int N_REQ = 4,
    parameter int LAT   = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*10-1:0]      req_a,
    input  logic [N_REQ*6-1:0]       req_b,
    output logic                     mul_ce,
    output logic [9:0]               mul_din0,
    output logic [5:0]               mul_din1,
    input  logic [15:0]              mul_dout,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(N_REQ)-1:0] res_id,
    output logic [15:0]              res_data,
    output logic                     busy
);

    localparam int IDW = $clog2(N_REQ);
    typedef logic [IDW-1:0] id_t;

    logic [N_REQ-1:0][9:0] a_arr;
    logic [N_REQ-1:0][5:0] b_arr;

    id_t                  ptr_q, ptr_d;
    logic [LAT-1:0]       vld_q, vld_d;
    logic [LAT-1:0][IDW-1:0] id_q, id_d;

    logic gnt_vld;
    id_t  gnt_id;
    int   idx;

    assign a_arr = req_a;
    assign b_arr = req_b;

    // A stalled result freezes both the external multiplier and the tag pipeline.
    assign mul_ce    = ~(vld_q[LAT-1] & ~res_ready);
    assign res_valid = vld_q[LAT-1];
    assign res_id    = id_q[LAT-1];
    assign res_data  = mul_dout;
    assign busy      = |vld_q;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!gnt_vld && req_valid[id_t'(idx)]) begin
                gnt_vld = 1'b1;
                gnt_id  = id_t'(idx);
            end
        end
        // No grant while stalled or held in reset, so req_ready drops immediately.
        if (!mul_ce || !reset_n) begin
            gnt_vld = 1'b0;
            gnt_id  = '0;
        end
    end

    always_comb begin
        req_ready = '0;
        mul_din0  = '0;
        mul_din1  = '0;
        if (gnt_vld) begin
            req_ready = N_REQ'(1) << gnt_id;
            mul_din0  = a_arr[gnt_id];
            mul_din1  = b_arr[gnt_id];
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        vld_d = vld_q;
        id_d  = id_q;
        if (gnt_vld) begin
            ptr_d = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + id_t'(1);
        end
        if (mul_ce) begin
            vld_d[0] = gnt_vld;
            id_d[0]  = gnt_id;
            for (int k = 1; k < LAT; k++) begin
                vld_d[k] = vld_q[k-1];
                id_d[k]  = id_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

endmodule

// File: tb/tb_kernel_attention_mul_arbiter.sv
// Bench for kernel_attention_mul_arbiter: pipelined multiplier model plus an in-order
// queue reference (ops age by enabled edges, leave at age LAT) driven by randomized traffic.
module tb_kernel_attention_mul_arbiter;
    localparam int N   = 4;
    localparam int LAT = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N-1:0][9:0] ra = '0;
    logic [N-1:0][5:0] rb = '0;
    logic             mul_ce;
    logic [9:0]       mul_din0;
    logic [5:0]       mul_din1;
    logic [15:0]      mul_dout;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [1:0]       res_id;
    logic [15:0]      res_data;
    logic             busy;

    always #5 clk = ~clk;

    kernel_attention_mul_arbiter #(.N_REQ(N), .LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(ra), .req_b(rb),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data),
        .busy(busy)
    );

    logic [15:0] mp [LAT];
    always @(posedge clk) begin
        if (mul_ce) begin
            mp[0] <= mul_din0 * mul_din1;
            for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
        end
    end
    assign mul_dout = mp[LAT-1];

    typedef struct { int id; int prod; int age; } ent_t;
    ent_t q[$];
    int   m_ptr = 0;
    int   n_pass = 0, n_total = 0;

    function automatic bit m_rv();
        return q.size() > 0 && q[0].age == LAT;
    endfunction

    function automatic int m_win(bit ce);
        if (!ce) return -1;
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    // Advance one clock; the reference moves only on enabled edges.
    task automatic tick();
        bit rv, ce;
        int w;
        rv = m_rv();
        ce = !(rv && !res_ready);
        w  = m_win(ce);
        @(posedge clk);
        if (reset_n && ce) begin
            if (rv) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (w >= 0) begin
                q.push_back('{w, int'(ra[w]) * int'(rb[w]), 1});
                m_ptr = (w + 1) % N;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = '0;
        q.delete();
        m_ptr = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        req_valid = 4'hF;
        #10;
        n_total++; if (req_ready !== 4'b0) $display("FAIL rst_ready: got %b exp 0000", req_ready); else n_pass++;
        n_total++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid: got %b exp 0", res_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
        @(negedge clk);
        req_valid = '0;
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        req_valid = 4'b0001;
        ra[0] = 10'd1023;
        rb[0] = 6'd63;
        #1;
        n_total++; if (req_ready !== 4'b0001) $display("FAIL single_grant: got %b exp 0001", req_ready); else n_pass++;
        tick();
        req_valid = '0;
        for (int e = 1; e < LAT; e++) begin
            #1;
            n_total++; if (res_valid !== 1'b0 || busy !== 1'b1)
                $display("FAIL single_early: edge %0d got valid=%b busy=%b exp 0/1", e, res_valid, busy); else n_pass++;
            tick();
        end
        #1;
        n_total++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 16'd64449)
            $display("FAIL single_result: got v=%b id=%0d d=%0d exp 1/0/64449", res_valid, res_id, res_data); else n_pass++;
        tick();
        #1;
        n_total++; if (busy !== 1'b0 || res_valid !== 1'b0)
            $display("FAIL single_drain: got busy=%b v=%b exp 0/0", busy, res_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        res_ready = 1'b1;
        req_valid = 4'hF;
        for (int c = 0; c < 24; c++) begin
            for (int i = 0; i < N; i++) begin ra[i] = 10'($urandom); rb[i] = 6'($urandom); end
            #1;
            n_total++; if (req_ready !== 4'(1 << (c % N)))
                $display("FAIL b2b_grant: cyc %0d got %b exp %b", c, req_ready, 4'(1 << (c % N))); else n_pass++;
            if (c >= LAT) begin
                n_total++; if (res_valid !== 1'b1 || res_id !== 2'((c - LAT) % N) || res_data !== 16'(q[0].prod))
                    $display("FAIL b2b_result: cyc %0d got v=%b id=%0d d=%0d exp 1/%0d/%0d",
                             c, res_valid, res_id, res_data, (c - LAT) % N, q[0].prod); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int guard;
        guard = 0;
        while (!m_rv() && guard < 10) begin tick(); guard++; end
        n_total++; if (res_valid !== 1'b1) $display("FAIL bp_setup: got v=%b exp 1", res_valid); else n_pass++;
        res_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_total++; if (mul_ce !== 1'b0 || req_ready !== 4'b0)
                $display("FAIL bp_stall: cyc %0d got ce=%b ready=%b exp 0/0000", c, mul_ce, req_ready); else n_pass++;
            n_total++; if (res_valid !== 1'b1 || res_id !== 2'(q[0].id) || res_data !== 16'(q[0].prod))
                $display("FAIL bp_hold: cyc %0d got v=%b id=%0d d=%0d exp 1/%0d/%0d",
                         c, res_valid, res_id, res_data, q[0].id, q[0].prod); else n_pass++;
            tick();
        end
        res_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c == 8) req_valid = '0;
            if (c > 8 && q.size() == 0) break;
            #1;
            n_total++; if (res_valid !== m_rv() || (m_rv() && (res_id !== 2'(q[0].id) || res_data !== 16'(q[0].prod))))
                $display("FAIL bp_resume: cyc %0d got v=%b id=%0d d=%0d exp v=%b", c, res_valid, res_id, res_data, m_rv()); else n_pass++;
            tick();
        end
        #1;
        n_total++; if (busy !== 1'b0 || q.size() != 0)
            $display("FAIL bp_drain: got busy=%b pending=%0d exp 0/0", busy, q.size()); else n_pass++;
    endtask

    task automatic test_sparse();
        int got_cyc[$], got_id[$], got_d[$];
        int stalls;
        stalls = 0;
        do_reset();
        res_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            req_valid = '0;
            if (c == 0) begin req_valid = 4'b0100; ra[2] = 10'd5; rb[2] = 6'd7; end
            if (c == 2) begin req_valid = 4'b0010; ra[1] = 10'd3; rb[1] = 6'd2; end
            #1;
            res_ready = res_valid;
            #1;
            if (mul_ce !== 1'b1) stalls++;
            if (res_valid === 1'b1) begin got_cyc.push_back(c); got_id.push_back(int'(res_id)); got_d.push_back(int'(res_data)); end
            tick();
        end
        res_ready = 1'b0;
        n_total++; if (stalls != 0) $display("FAIL sparse_stall: got %0d stalled cycles exp 0", stalls); else n_pass++;
        n_total++; if (got_cyc.size() != 2) $display("FAIL sparse_count: got %0d results exp 2", got_cyc.size()); else begin
            n_pass++;
            n_total++; if (got_cyc[0] != 3 || got_id[0] != 2 || got_d[0] != 35)
                $display("FAIL sparse_first: got cyc=%0d id=%0d d=%0d exp 3/2/35", got_cyc[0], got_id[0], got_d[0]); else n_pass++;
            n_total++; if (got_cyc[1] != 5 || got_id[1] != 1 || got_d[1] != 6)
                $display("FAIL sparse_second: got cyc=%0d id=%0d d=%0d exp 5/1/6", got_cyc[1], got_id[1], got_d[1]); else n_pass++;
        end
    endtask

    task automatic test_random();
        bit rv, ce;
        int w;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom);
            for (int i = 0; i < N; i++) begin ra[i] = 10'($urandom); rb[i] = 6'($urandom); end
            if (c % 50 == 7) begin ra[0] = 10'd1023; rb[0] = 6'd63; end
            res_ready = ($urandom_range(0, 9) < 7);
            #1;
            rv = m_rv();
            ce = !(rv && !res_ready);
            w  = m_win(ce);
            n_total++; if (req_ready !== ((w >= 0) ? 4'(1 << w) : 4'b0))
                $display("FAIL rnd_grant: cyc %0d got %b exp winner %0d", c, req_ready, w); else n_pass++;
            n_total++; if (mul_ce !== ce || res_valid !== rv || busy !== (q.size() > 0))
                $display("FAIL rnd_ctrl: cyc %0d got ce=%b v=%b busy=%b exp %b/%b/%b", c, mul_ce, res_valid, busy, ce, rv, q.size() > 0); else n_pass++;
            n_total++; if (mul_din0 !== ((w >= 0) ? ra[w] : 10'd0) || mul_din1 !== ((w >= 0) ? rb[w] : 6'd0))
                $display("FAIL rnd_operands: cyc %0d got %0d,%0d winner %0d", c, mul_din0, mul_din1, w); else n_pass++;
            if (rv) begin
                n_total++; if (res_id !== 2'(q[0].id) || res_data !== 16'(q[0].prod))
                    $display("FAIL rnd_result: cyc %0d got id=%0d d=%0d exp %0d/%0d", c, res_id, res_data, q[0].id, q[0].prod); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        res_ready = 1'b1;
        req_valid = 4'b0110;
        for (int c = 0; c < 3; c++) tick();
        reset_n = 1'b0;
        #1;
        n_total++; if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0)
            $display("FAIL midrst_async: got v=%b busy=%b ready=%b exp 0/0/0000", res_valid, busy, req_ready); else n_pass++;
        q.delete();
        m_ptr = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        req_valid = '0;
        for (int c = 0; c < LAT + 3; c++) begin
            #1;
            n_total++; if (res_valid !== 1'b0) $display("FAIL midrst_ghost: cyc %0d got v=%b exp 0", c, res_valid); else n_pass++;
            tick();
        end
        req_valid = 4'hF;
        #1;
        n_total++; if (req_ready !== 4'b0001) $display("FAIL midrst_ptr: got %b exp 0001", req_ready); else n_pass++;
        tick();
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_sparse();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
